gpio_cfg_tx: RTL and testbench

GPIO_CFG_TX -- requirements
Module: gpio_cfg_tx

---
 rtl/gpio_cfg_tx_pkg.sv | 16 +
 rtl/gpio_cfg_tx_cmd_fifo.sv | 40 ++++
 rtl/gpio_cfg_tx.sv | 113 +++++++++++
 tb/tb_gpio_cfg_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_tx_pkg.sv
// ising_config: GPIO field layout, command type and FSM states shared by gpio_cfg_tx and its queue
package ising_config;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int GPIO_W   = 32;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 15;
  localparam int DATA_LSB = 16;
  localparam int DATA_MSB = 23;
  localparam int WCLK_BIT = 24;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } gpio_cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} tx_state_e;
endpackage

// File: rtl/gpio_cfg_tx_cmd_fifo.sv
// gpio_cmd_fifo: command queue of gpio_cmd_t; a full queue refuses pushes even on a popping edge
module gpio_cmd_fifo
  import ising_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  gpio_cmd_t din_i,
  output gpio_cmd_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);
  gpio_cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic push_ok, pop_ok;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_ok);
      rd_q  <= rd_q + AW'(pop_ok);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/gpio_cfg_tx.sv
// gpio_cfg_tx: config writes bit-banged onto gpio_out (setup/strobe/hold); ISING_GPIO_TX_FIFO_EN adds a command queue
module gpio_cfg_tx
  import ising_config::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              busy,
  output logic              tx_done
);
  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("gpio_cfg_tx: parameter out of range");
  end
  tx_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  gpio_cmd_t cmd_q, cmd_d, next_cmd;
  logic wclk_q, wclk_d;
  logic cmd_avail, load;
  logic setup_last, strobe_last, hold_last;
`ifdef ISING_GPIO_TX_FIFO_EN
  logic fifo_full, fifo_empty;
  gpio_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (load),
    .din_i   (gpio_cmd_t'({cmd_addr, cmd_data})),
    .dout_o  (next_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign cmd_ready = !rst && !fifo_full;
  assign cmd_avail = !fifo_empty;
  assign busy      = state_q != ST_IDLE || !fifo_empty;
`else
  // Without a queue the command is taken straight from the port while idle.
  assign cmd_ready = !rst && state_q == ST_IDLE;
  assign cmd_avail = cmd_valid && cmd_ready;
  assign next_cmd  = gpio_cmd_t'({cmd_addr, cmd_data});
  assign busy      = state_q != ST_IDLE;
`endif
  assign setup_last  = state_q == ST_SETUP && cnt_q == 4'(SETUP_CYC - 1);
  assign strobe_last = state_q == ST_STROBE && cnt_q == 4'(STROBE_CYC - 1);
  assign hold_last   = state_q == ST_HOLD && cnt_q == 4'(HOLD_CYC - 1);
  assign tx_done     = hold_last;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    cmd_d   = cmd_q;
    wclk_d  = wclk_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_avail) begin
          state_d = ST_SETUP;
          load    = 1'b1;
        end
      end
      ST_SETUP: if (setup_last) begin
        state_d = ST_STROBE;
        cnt_d   = '0;
        wclk_d  = 1'b1;
      end
      ST_STROBE: if (strobe_last) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        wclk_d  = 1'b0;
      end
      ST_HOLD: if (hold_last) begin
        state_d = cmd_avail ? ST_SETUP : ST_IDLE;
        cnt_d   = '0;
        load    = cmd_avail;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        wclk_d  = 1'b0;
      end
    endcase
    if (load) cmd_d = next_cmd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      wclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      wclk_q  <= wclk_d;
    end
  end
  always_comb begin
    gpio_out                    = '0;
    gpio_out[ADDR_MSB:ADDR_LSB] = cmd_q.addr;
    gpio_out[DATA_MSB:DATA_LSB] = cmd_q.data;
    gpio_out[WCLK_BIT]          = wclk_q;
  end
endmodule

// File: tb/tb_gpio_cfg_tx.sv
// tb_gpio_cfg_tx: random and directed checks of gpio_cfg_tx against a frame-position reference model
module tb_gpio_cfg_tx;
  import ising_config::*;
  localparam int S = 2, T = 2, H = 2, L = S + T + H, DEPTH = 4;
`ifdef ISING_GPIO_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif
  localparam int GAP = FIFO_ON ? L : L + 1;
  localparam logic [33:0] SINGLE_TBL [7] = '{
    {32'h005A0100, 1'b0, 1'b1}, {32'h005A0100, 1'b0, 1'b1},
    {32'h015A0100, 1'b0, 1'b1}, {32'h015A0100, 1'b0, 1'b1},
    {32'h005A0100, 1'b0, 1'b1}, {32'h005A0100, 1'b1, 1'b1},
    {32'h005A0100, 1'b0, 1'b0}};
  localparam logic [32:0] FAST_TBL [4] = '{
    {32'h00C3BEEF, 1'b0}, {32'h01C3BEEF, 1'b0}, {32'h00C3BEEF, 1'b1}, {32'h00C3BEEF, 1'b0}};
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, busy, tx_done;
  logic [15:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [31:0] gpio_out;
  logic f_valid = 1'b0, f_ready, f_busy, f_done;
  logic [15:0] f_addr = '0;
  logic [7:0] f_data = '0;
  logic [31:0] f_gpio;
  int n_checks = 0, n_errors = 0;
  gpio_cfg_tx dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .gpio_out(gpio_out), .busy(busy), .tx_done(tx_done));
  gpio_cfg_tx #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (.clk(clk), .rst(rst),
    .cmd_valid(f_valid), .cmd_ready(f_ready), .cmd_addr(f_addr), .cmd_data(f_data),
    .gpio_out(f_gpio), .busy(f_busy), .tx_done(f_done));
  // Reference model: pos is the cycle index inside the current frame, -1 when idle.
  int pos = -1, mq_n = 0;
  gpio_cmd_t cur = '0;
  gpio_cmd_t mq[$];
  bit m_acc = 1'b0;
  always @(posedge clk) begin
    bit acc, free;
    acc  = cmd_valid && !rst && (FIFO_ON ? mq.size() < DEPTH : pos < 0);
    free = pos < 0 || pos == L - 1;
    if (rst) begin
      pos = -1;
      cur = '0;
      mq.delete();
      m_acc = 1'b0;
    end else begin
      if (FIFO_ON) begin
        if (free && mq.size() > 0) begin
          cur = mq.pop_front();
          pos = 0;
        end else if (free) pos = -1;
        else pos++;
        if (acc) mq.push_back(gpio_cmd_t'({cmd_addr, cmd_data}));
      end else begin
        if (pos < 0 && acc) begin
          cur = gpio_cmd_t'({cmd_addr, cmd_data});
          pos = 0;
        end else if (free) pos = -1;
        else pos++;
      end
      m_acc = acc;
    end
    mq_n = mq.size();
  end
  logic exp_wclk;
  logic [34:0] exp_vec, got_vec;
  assign exp_wclk = pos >= S && pos < S + T;
  assign exp_vec = {7'b0, exp_wclk, cur.data, cur.addr, pos == L - 1, pos >= 0 || mq_n > 0,
                    !rst && (FIFO_ON ? mq_n < DEPTH : pos < 0)};
  assign got_vec = {gpio_out, tx_done, busy, cmd_ready};
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (got_vec !== 35'h0) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=%h", got_vec, 35'h0);
    end
    n_checks++;
    if ({f_gpio, f_done, f_busy, f_ready} !== 35'h0) begin
      n_errors++;
      $display("FAIL reset_state_fast got=%h exp=0", {f_gpio, f_done, f_busy, f_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || got_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL reset_release got=%h exp=%h", got_vec, exp_vec);
    end
  endtask
  task automatic test_single();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0100;
    cmd_data  = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (FIFO_ON) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if ({gpio_out, tx_done, busy} !== SINGLE_TBL[i] || got_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h model=%h", i, {gpio_out, tx_done, busy}, SINGLE_TBL[i], exp_vec);
      end
    end
  endtask
  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
      end
      if (cmd_valid && m_acc) cmd_valid = 1'b0;
      if (!cmd_valid && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_addr  = 16'($urandom);
        cmd_data  = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 200 && (pos >= 0 || mq_n > 0); c++) begin
      @(negedge clk);
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL random_idle busy=%b exp=0", busy);
    end
  endtask
  task automatic test_back_to_back(input int n, output bit saw_low);
    int sent = 0, dones = 0, last = -1;
    saw_low   = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 16'($urandom);
    cmd_data  = 8'($urandom);
    for (int c = 0; c < 400 && dones < n; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
      end
      if (sent < n && cmd_ready !== 1'b1) saw_low = 1'b1;
      if (tx_done === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (c - last != GAP) begin
            n_errors++;
            $display("FAIL b2b_gap got=%0d exp=%0d", c - last, GAP);
          end
        end
        last = c;
        dones++;
      end
      if (m_acc) begin
        sent++;
        if (sent == n) cmd_valid = 1'b0;
        else begin
          cmd_addr = 16'($urandom);
          cmd_data = 8'($urandom);
        end
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (dones != n) begin
      n_errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", dones, n);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_fifo_full();
    bit low;
    test_back_to_back(4, low);
    n_checks++;
    if (low) begin
      n_errors++;
      $display("FAIL burst4_ready got=dropped exp=held_high");
    end
    test_back_to_back(7, low);
    n_checks++;
    if (!low) begin
      n_errors++;
      $display("FAIL burst7_ready got=never_low exp=low_when_full");
    end
  endtask
  task automatic test_fast();
    int hi = 0;
    @(negedge clk);
    f_valid = 1'b1;
    f_addr  = 16'hBEEF;
    f_data  = 8'hC3;
    @(negedge clk);
    f_valid = 1'b0;
    if (FIFO_ON) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      hi += int'(f_gpio[24]);
      n_checks++;
      if ({f_gpio, f_done} !== FAST_TBL[i]) begin
        n_errors++;
        $display("FAIL fast cyc=%0d got=%h exp=%h", i, {f_gpio, f_done}, FAST_TBL[i]);
      end
    end
    n_checks++;
    if (hi != 1 || f_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL fast_strobe_width got=%0d busy=%b exp=1 busy=0", hi, f_busy);
    end
  endtask
  task automatic test_reset_mid();
    int sent = 0, d = 0;
    bit hit = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 16'($urandom);
    cmd_data  = 8'($urandom);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
      end
      if (pos == L - 1) d++;
      if (m_acc) begin
        sent++;
        if (sent == 3) cmd_valid = 1'b0;
        else begin
          cmd_addr = 16'($urandom);
          cmd_data = 8'($urandom);
        end
      end
      if (d == 1 && exp_wclk) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL rstmid_timeout got=no_strobe exp=strobe_of_cmd2");
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (got_vec !== 35'h0) begin
      n_errors++;
      $display("FAIL rstmid_reset got=%h exp=0", got_vec);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b0 || gpio_out !== 32'h0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL rstmid_after cyc=%0d gpio=%h done=%b busy=%b exp=0", c, gpio_out, tx_done, busy);
      end
    end
  endtask
  initial begin
    bit low;
    test_reset();
    test_single();
    test_random(400);
    test_back_to_back(3, low);
`ifdef ISING_GPIO_TX_FIFO_EN
    test_fifo_full();
`endif
    test_fast();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
